// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared defines, widths, state encodings and constants for the fetch unit
`ifndef IFU_DEFINES_SVH
`define IFU_DEFINES_SVH
`define CPU_RESET_ADDR 32'h8000_0000
`define INST_NOP       32'h0000_0013
`define AXI_ADDR_BUS   31:0
`define AXI_DATA_BUS   31:0
`define AXI_RESP_BUS   1:0
`define AXI_RESP_OKAY  2'b00
`define IFU_STATE_BUS  1:0
`define IFU_S_REQ      2'd0
`define IFU_S_RESP     2'd1
`define IFU_S_OUT      2'd2
`endif

package ifu_fetch_pkg;

    typedef logic [`AXI_ADDR_BUS] addr_t;
    typedef logic [`AXI_DATA_BUS] data_t;
    typedef logic [`AXI_RESP_BUS] resp_t;

    localparam addr_t CPU_RESET_ADDR = `CPU_RESET_ADDR;
    localparam data_t INST_NOP       = `INST_NOP;
    localparam resp_t AXI_RESP_OKAY  = `AXI_RESP_OKAY;

    typedef enum logic [`IFU_STATE_BUS] {
        S_REQ  = `IFU_S_REQ,
        S_RESP = `IFU_S_RESP,
        S_OUT  = `IFU_S_OUT
    } ifu_state_t;

endpackage

// File: rtl/ifu_pc_gen.sv
// rtl/ifu_pc_gen.sv - PC register, pending redirect PC, discard flag and next-PC selection

module ifu_pc_gen
    import ifu_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = CPU_RESET_ADDR,
    parameter addr_t PC_STEP  = 32'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  ifu_state_t state,
    input  logic       r_done,
    input  logic       d_done,
    input  logic       redirect_valid,
    input  addr_t      redirect_pc,
    output addr_t      pc,
    output logic       drop
);

    addr_t pend_pc;
    logic  discard;

    // A response is dropped if a redirect was seen earlier in this fetch or arrives with the R beat.
    assign drop = r_done && (discard || redirect_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            pend_pc <= RESET_PC;
            discard <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                        discard <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (drop) begin
                        pc      <= redirect_valid ? redirect_pc : pend_pc;
                        discard <= 1'b0;
                    end else if (redirect_valid) begin
                        pend_pc <= redirect_pc;
                        discard <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (d_done) begin
                        pc <= pc + PC_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: single-outstanding AXI-lite read master feeding decode

module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter addr_t RESET_PC = CPU_RESET_ADDR,
    parameter addr_t PC_STEP  = 32'd4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [`AXI_ADDR_BUS] araddr,
    output logic                 arvalid,
    input  logic                 arready,
    input  logic [`AXI_DATA_BUS] rdata,
    input  logic [`AXI_RESP_BUS] rresp,
    input  logic                 rvalid,
    output logic                 rready,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [`AXI_DATA_BUS] inst,
    output logic [`AXI_ADDR_BUS] inst_pc,
    output logic                 inst_err,
    input  logic                 redirect_valid,
    input  logic [`AXI_ADDR_BUS] redirect_pc
);

    ifu_state_t state;
    ifu_state_t state_next;
    addr_t      pc;
    logic       drop;
    logic       ar_done;
    logic       r_done;
    logic       d_done;

    assign ar_done = arvalid && arready;
    assign r_done  = rvalid && rready;
    assign d_done  = inst_valid && inst_ready;
    assign araddr  = pc;

    ifu_pc_gen #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_gen (
        .clk            (clk),
        .rst_n          (rst_n),
        .state          (state),
        .r_done         (r_done),
        .d_done         (d_done),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .drop           (drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ:   if (ar_done) state_next = S_RESP;
            S_RESP:  if (r_done) state_next = drop ? S_REQ : S_OUT;
            S_OUT:   if (d_done || redirect_valid) state_next = S_REQ;
            default: state_next = S_REQ;
        endcase
    end

    // Handshake outputs are held low while reset is asserted.
    always_comb begin
        arvalid    = rst_n && (state == S_REQ);
        rready     = rst_n && (state == S_RESP);
        inst_valid = rst_n && (state == S_OUT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst     <= INST_NOP;
            inst_pc  <= RESET_PC;
            inst_err <= 1'b0;
        end else if (r_done && !drop) begin
            inst     <= (rresp == AXI_RESP_OKAY) ? rdata : INST_NOP;
            inst_err <= (rresp != AXI_RESP_OKAY);
            inst_pc  <= pc;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed bench for ifu_fetch with a behavioural instruction SRAM slave

module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .araddr         (araddr),
        .arvalid        (arvalid),
        .arready        (arready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rvalid         (rvalid),
        .rready         (rready),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ard;
        int          rd;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    int tests = 0;
    int fails = 0;

    int          ar_delay = 0;
    int          r_delay = 0;
    logic [31:0] cfg_data = 32'h13;
    logic [1:0]  cfg_resp = 2'b00;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    logic        r_pend = 1'b0;
    logic        ar_hs = 1'b0;
    logic        r_hs = 1'b0;
    logic        d_hs = 1'b0;
    logic [31:0] d_pc, d_inst;
    logic        d_err;
    logic [31:0] last_ar = 32'h0;
    logic        prev_arv = 1'b0;
    logic [31:0] prev_ara = 32'h0;
    int          stab_err = 0;

    logic [31:0] ar_q[$];
    logic [31:0] acc_pc_q[$];
    logic [31:0] acc_inst_q[$];
    logic        acc_err_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: settle after the edge, advance the slave, drive decode/redirect inputs for the next edge.
    task automatic tick(input logic rdy, input logic rv, input logic [31:0] rp);
        @(posedge clk);
        #1;
        if (d_hs) begin
            acc_pc_q.push_back(d_pc);
            acc_inst_q.push_back(d_inst);
            acc_err_q.push_back(d_err);
        end
        if (!rst_n) begin
            arready = 1'b0;
            rvalid  = 1'b0;
            r_pend  = 1'b0;
            ar_cnt  = 0;
            r_cnt   = 0;
            prev_arv = 1'b0;
        end else begin
            if (prev_arv && !ar_hs && (!arvalid || araddr !== prev_ara)) stab_err++;
            if (rready && araddr !== last_ar) stab_err++;
            prev_arv = arvalid;
            prev_ara = araddr;
            if (r_hs) begin
                rvalid = 1'b0;
                r_pend = 1'b0;
            end
            if (ar_hs) begin
                r_pend = 1'b1;
                r_cnt  = 0;
                ar_cnt = 0;
            end
            arready = 1'b0;
            if (arvalid && !r_pend) begin
                if (ar_cnt >= ar_delay) arready = 1'b1;
                else ar_cnt++;
            end
            if (r_pend && !rvalid) begin
                if (r_cnt >= r_delay) begin
                    rvalid = 1'b1;
                    rdata  = cfg_data;
                    rresp  = cfg_resp;
                end else begin
                    r_cnt++;
                end
            end
        end
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;
        ar_hs  = arvalid && arready;
        r_hs   = rvalid && rready;
        d_hs   = inst_valid && inst_ready;
        d_pc   = inst_pc;
        d_inst = inst;
        d_err  = inst_err;
        if (ar_hs) begin
            ar_q.push_back(araddr);
            last_ar = araddr;
        end
    endtask

    task automatic wait_acc(input int n, input string name);
        int b;
        b = 0;
        while (acc_pc_q.size() < n && b < 200) begin
            tick(1'b1, 1'b0, 32'h0);
            b++;
        end
        if (acc_pc_q.size() < n) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout, got %0d accepted, required %0d", name, acc_pc_q.size(), n);
        end
    endtask

    task automatic wait_sig(input int which, input logic rdy, input string name);
        int b;
        b = 0;
        while (((which == 0) ? !inst_valid : !rready) && b < 100) begin
            tick(rdy, 1'b0, 32'h0);
            b++;
        end
        if (b >= 100) begin
            tests++;
            fails++;
            $display("FAIL %s: timeout waiting, got 0 required 1", name);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [31:0] exp_pc, pc0, i0, pc_cur;
    int          stall_bad;
    logic        saw;

    initial begin
        vecs[0] = '{0, 0, 32'h0000_0013, 2'b00, 32'h0000_0013, 1'b0};
        vecs[1] = '{0, 0, 32'h0000_0013, 2'b00, 32'h0000_0013, 1'b0};
        vecs[2] = '{2, 1, 32'h00a0_0093, 2'b00, 32'h00a0_0093, 1'b0};
        vecs[3] = '{0, 0, 32'hdead_beef, 2'b10, 32'h0000_0013, 1'b1};
        vecs[4] = '{1, 3, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
        vecs[5] = '{0, 2, 32'hcafe_f00d, 2'b11, 32'h0000_0013, 1'b1};
        vecs[6] = '{3, 4, 32'h0000_0073, 2'b00, 32'h0000_0073, 1'b0};

        rst_n = 1'b0;
        arready = 1'b0;
        rvalid = 1'b0;
        rdata = 32'h0;
        rresp = 2'b00;
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        check("rst_arvalid", {31'b0, arvalid}, 32'd0);
        check("rst_rready", {31'b0, rready}, 32'd0);
        check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_araddr", araddr, 32'h8000_0000);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_inst_pc", inst_pc, 32'h8000_0000);
        check("rst_inst_err", {31'b0, inst_err}, 32'd0);

        ar_delay = vecs[0].ard;
        r_delay  = vecs[0].rd;
        cfg_data = vecs[0].data;
        cfg_resp = vecs[0].resp;
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 32'h0);
        check("first_arvalid", {31'b0, arvalid}, 32'd1);
        check("first_araddr", araddr, 32'h8000_0000);

        exp_pc = 32'h8000_0000;
        for (int i = 0; i < 7; i++) begin
            ar_delay = vecs[i].ard;
            r_delay  = vecs[i].rd;
            cfg_data = vecs[i].data;
            cfg_resp = vecs[i].resp;
            wait_acc(i + 1, $sformatf("vec%0d_wait", i));
            check($sformatf("vec%0d_inst_pc", i), acc_pc_q[i], exp_pc);
            check($sformatf("vec%0d_inst", i), acc_inst_q[i], vecs[i].exp_inst);
            check($sformatf("vec%0d_inst_err", i), {31'b0, acc_err_q[i]}, {31'b0, vecs[i].exp_err});
            check($sformatf("vec%0d_araddr", i), ar_q[i], exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        check("table_addr_stable", stab_err, 0);

        // Decode back-pressure for five cycles.
        ar_delay = 0;
        r_delay  = 0;
        wait_sig(0, 1'b0, "stall_wait");
        pc0 = inst_pc;
        i0  = inst;
        stall_bad = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b0, 32'h0);
            if (!inst_valid || inst_pc !== pc0 || inst !== i0 || arvalid) stall_bad++;
        end
        check("stall_pc", pc0, 32'h8000_001c);
        check("stall_inst", i0, 32'h0000_0073);
        check("stall_hold", stall_bad, 0);
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        check("post_stall_arvalid", {31'b0, arvalid}, 32'd1);
        check("post_stall_araddr", araddr, 32'h8000_0020);

        // Two redirects while in S_RESP: the later one wins, the response is dropped.
        r_delay = 3;
        wait_sig(1, 1'b1, "resp_wait");
        ar_q.delete();
        acc_pc_q.delete();
        acc_inst_q.delete();
        acc_err_q.delete();
        saw = 1'b0;
        tick(1'b1, 1'b1, 32'h8000_0180);
        saw = saw | inst_valid;
        tick(1'b1, 1'b1, 32'h8000_0100);
        saw = saw | inst_valid;
        for (int b = 0; b < 100 && ar_q.size() < 1; b++) begin
            tick(1'b1, 1'b0, 32'h0);
            saw = saw | inst_valid;
        end
        check("discard_no_valid", {31'b0, saw}, 32'd0);
        check("discard_next_araddr", ar_q[0], 32'h8000_0100);
        wait_acc(1, "redir_acc_wait");
        check("redir_inst_pc", acc_pc_q[0], 32'h8000_0100);

        // Redirect on the same cycle as the decode handshake.
        r_delay = 0;
        wait_sig(0, 1'b0, "hs_redir_wait");
        pc_cur = inst_pc;
        acc_pc_q.delete();
        acc_inst_q.delete();
        acc_err_q.delete();
        tick(1'b1, 1'b1, 32'h8000_0200);
        tick(1'b0, 1'b0, 32'h0);
        check("hs_redir_pc_cur", pc_cur, 32'h8000_0104);
        check("hs_redir_arvalid", {31'b0, arvalid}, 32'd1);
        check("hs_redir_araddr", araddr, 32'h8000_0200);
        check("hs_redir_consumed", acc_pc_q.size(), 1);
        check("hs_redir_consumed_pc", acc_pc_q[0], pc_cur);

        // Redirect in S_OUT without a handshake, slow slave, PC wrap.
        ar_delay = 3;
        r_delay  = 4;
        cfg_data = 32'h0000_0013;
        cfg_resp = 2'b00;
        wait_sig(0, 1'b0, "wrap_wait");
        check("out_redir_pc", inst_pc, 32'h8000_0200);
        acc_pc_q.delete();
        acc_inst_q.delete();
        acc_err_q.delete();
        ar_q.delete();
        stab_err = 0;
        tick(1'b0, 1'b1, 32'hffff_fffc);
        tick(1'b1, 1'b0, 32'h0);
        check("out_redir_arvalid", {31'b0, arvalid}, 32'd1);
        check("out_redir_araddr", araddr, 32'hffff_fffc);
        check("out_redir_not_consumed", acc_pc_q.size(), 0);
        wait_acc(1, "wrap_acc1");
        check("wrap_pc0", acc_pc_q[0], 32'hffff_fffc);
        wait_acc(2, "wrap_acc2");
        check("wrap_pc1", acc_pc_q[1], 32'h0000_0000);
        check("wrap_ar0", ar_q[0], 32'hffff_fffc);
        check("wrap_ar1", ar_q[1], 32'h0000_0000);
        check("stall_addr_stable", stab_err, 0);

        // Reset in the middle of a read.
        ar_delay = 0;
        r_delay  = 5;
        wait_sig(1, 1'b1, "midrst_wait");
        rst_n = 1'b0;
        tick(1'b1, 1'b0, 32'h0);
        check("midrst_arvalid", {31'b0, arvalid}, 32'd0);
        check("midrst_rready", {31'b0, rready}, 32'd0);
        check("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check("midrst_araddr", araddr, 32'h8000_0000);
        check("midrst_inst_pc", inst_pc, 32'h8000_0000);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 32'h0);
        check("midrst_rel_arvalid", {31'b0, arvalid}, 32'd1);
        check("midrst_rel_araddr", araddr, 32'h8000_0000);
        check("midrst_rel_rready", {31'b0, rready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
